// File: rtl/complex_abs_peak_if.sv
// Sample-stream bundle between the complex matched filter, the magnitude/peak stage and the detector.
// The master side drives the complex samples; the slave side returns magnitudes and the peak report.
interface complex_abs_peak_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int INDEX_WIDTH = 16
);
    logic                         dataInValid;
    logic signed [DATA_WIDTH-1:0] dataInRe;
    logic signed [DATA_WIDTH-1:0] dataInIm;
    logic        [DATA_WIDTH:0]   magOut;
    logic                         magOutValid;
    logic        [DATA_WIDTH:0]   peakValue;
    logic        [INDEX_WIDTH-1:0] peakIndex;
    logic                         peakValidFlag;

    modport master (
        output dataInValid, dataInRe, dataInIm,
        input  magOut, magOutValid, peakValue, peakIndex, peakValidFlag
    );

    modport slave (
        input  dataInValid, dataInRe, dataInIm,
        output magOut, magOutValid, peakValue, peakIndex, peakValidFlag
    );
endinterface

// File: rtl/complex_abs_peak.sv
// Alpha-max-plus-beta-min magnitude (max + 3/8 min) with a per-frame peak search and report.
// Optional macro PEAK_THRESHOLD_EN adds a threshold input and a detectFlag output.
module complex_abs_peak #(
    parameter int DATA_WIDTH   = 16,
    parameter int FRAME_LENGTH = 33000,
    parameter int INDEX_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
`ifdef PEAK_THRESHOLD_EN
    input  logic [DATA_WIDTH:0]   threshold,
    output logic                  detectFlag,
`endif
    output logic                  busy,
    complex_abs_peak_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} stateType;

    localparam logic [DATA_WIDTH-1:0]  ONE        = DATA_WIDTH'(1);
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(FRAME_LENGTH - 1);
    localparam logic [INDEX_WIDTH-1:0] INDEX_ONE  = INDEX_WIDTH'(1);

    stateType state, nextState;

    logic [DATA_WIDTH-1:0] reBits, imBits, absRe, absIm;
    logic [DATA_WIDTH-1:0] s1Re, s1Im, s2Max, s2Min;
    logic                  s1Valid, s2Valid;
    logic [DATA_WIDTH:0]   magReg;
    logic                  magValidReg;

    logic [INDEX_WIDTH-1:0] sampleCount, runIndex, peakIndexReg;
    logic [DATA_WIDTH:0]    runPeak, peakValueReg;
    logic                   peakFlagReg;

    // Two's-complement negate on the raw bits so the most negative input maps to 2^(W-1).
    assign reBits = bus.dataInRe;
    assign imBits = bus.dataInIm;
    assign absRe  = reBits[DATA_WIDTH-1] ? (~reBits + ONE) : reBits;
    assign absIm  = imBits[DATA_WIDTH-1] ? (~imBits + ONE) : imBits;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1Re        <= '0;
            s1Im        <= '0;
            s1Valid     <= 1'b0;
            s2Max       <= '0;
            s2Min       <= '0;
            s2Valid     <= 1'b0;
            magReg      <= '0;
            magValidReg <= 1'b0;
        end else begin
            s1Valid <= bus.dataInValid;
            if (bus.dataInValid) begin
                s1Re <= absRe;
                s1Im <= absIm;
            end
            s2Valid <= s1Valid;
            if (s1Valid) begin
                if (s1Re >= s1Im) begin
                    s2Max <= s1Re;
                    s2Min <= s1Im;
                end else begin
                    s2Max <= s1Im;
                    s2Min <= s1Re;
                end
            end
            magValidReg <= s2Valid;
            if (s2Valid) begin
                magReg <= {1'b0, s2Max} + {3'b000, s2Min[DATA_WIDTH-1:2]}
                        + {4'b0000, s2Min[DATA_WIDTH-1:3]};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (enable) nextState = RUN;
            RUN:  if (magValidReg && sampleCount == LAST_INDEX) nextState = DONE;
            DONE: nextState = enable ? RUN : IDLE;
            default: nextState = IDLE;
        endcase
    end

    // A zero counter marks the first sample of a frame, so the running peak never needs a sentinel.
    always_ff @(posedge clock) begin
        if (reset) begin
            sampleCount  <= '0;
            runPeak      <= '0;
            runIndex     <= '0;
            peakValueReg <= '0;
            peakIndexReg <= '0;
            peakFlagReg  <= 1'b0;
`ifdef PEAK_THRESHOLD_EN
            detectFlag   <= 1'b0;
`endif
        end else begin
            peakFlagReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        sampleCount <= '0;
                        runPeak     <= '0;
                        runIndex    <= '0;
                    end
                end
                RUN: begin
                    if (magValidReg) begin
                        if (sampleCount == '0 || magReg > runPeak) begin
                            runPeak  <= magReg;
                            runIndex <= sampleCount;
                        end
                        sampleCount <= sampleCount + INDEX_ONE;
                    end
                end
                DONE: begin
                    peakValueReg <= runPeak;
                    peakIndexReg <= runIndex;
                    peakFlagReg  <= 1'b1;
                    sampleCount  <= '0;
`ifdef PEAK_THRESHOLD_EN
                    detectFlag   <= (runPeak > threshold);
`endif
                end
                default: begin
                    sampleCount <= '0;
                end
            endcase
        end
    end

    assign bus.magOut        = magReg;
    assign bus.magOutValid   = magValidReg;
    assign bus.peakValue     = peakValueReg;
    assign bus.peakIndex     = peakIndexReg;
    assign bus.peakValidFlag = peakFlagReg;
    assign busy              = (state != IDLE);
endmodule

// File: tb/tb_complex_abs_peak.sv
// Bench for complex_abs_peak: magnitude delay-line model plus a per-frame peak scoreboard.
// Inputs change on the falling edge; all outputs are compared on the falling edge.
module tb_complex_abs_peak;
    localparam int DW = 16;
    localparam int FL = 8;
    localparam int IW = 16;

    logic clock = 1'b0;
    logic reset;
    logic enable;
    logic busy;
`ifdef PEAK_THRESHOLD_EN
    logic [DW:0] threshold;
    logic        detectFlag;
    bit          expDetQ[$];
`endif

    complex_abs_peak_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) bus ();

    complex_abs_peak #(.DATA_WIDTH(DW), .FRAME_LENGTH(FL), .INDEX_WIDTH(IW)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
`ifdef PEAK_THRESHOLD_EN
        .threshold  (threshold),
        .detectFlag (detectFlag),
`endif
        .busy       (busy),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    int   errors = 0;
    int   checks = 0;
    int   reportCount = 0;
    int   thresholdVal = 100;
    logic expV1, expV2, expV3;
    int   expM1, expM2, expM3, expMag;
    int   expPeakQ[$];
    int   expIdxQ[$];
    int   frameMags[FL];

    function automatic int magModel(input int re, input int im);
        int a, b, mx, mn;
        a  = (re < 0) ? -re : re;
        b  = (im < 0) ? -im : im;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        return mx + mn / 4 + mn / 8;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareAll();
        int p, ix;
        checkOutput("magOutValid", int'(bus.magOutValid), int'(expV3));
        checkOutput("magOut", int'(bus.magOut), expMag);
        if (bus.peakValidFlag) begin
            reportCount++;
            if (expPeakQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedPeak: got peakValidFlag=1 expected 0 at %0t", $time);
            end else begin
                p  = expPeakQ.pop_front();
                ix = expIdxQ.pop_front();
                checkOutput("peakValue", int'(bus.peakValue), p);
                checkOutput("peakIndex", int'(bus.peakIndex), ix);
`ifdef PEAK_THRESHOLD_EN
                checkOutput("detectFlag", int'(detectFlag), int'(expDetQ.pop_front()));
`endif
            end
        end
    endtask

    // Model advances on the rising edge using the inputs the DUT sees there.
    task automatic tick();
        @(posedge clock);
        if (reset) begin
            expV1  = 1'b0;
            expV2  = 1'b0;
            expV3  = 1'b0;
            expMag = 0;
        end else begin
            expV3 = expV2;
            expM3 = expM2;
            expV2 = expV1;
            expM2 = expM1;
            expV1 = bus.dataInValid;
            expM1 = magModel(int'(bus.dataInRe), int'(bus.dataInIm));
            if (expV3) expMag = expM3;
        end
        @(negedge clock);
        compareAll();
    endtask

    task automatic applyStimulus(input logic v, input int re, input int im);
        bus.dataInValid = v;
        bus.dataInRe    = DW'(re);
        bus.dataInIm    = DW'(im);
        tick();
    endtask

    task automatic sendFrame(input bit toggle, input int dropEnableAt);
        int pk, ix;
        pk = frameMags[0];
        ix = 0;
        for (int i = 1; i < FL; i++) begin
            if (frameMags[i] > pk) begin
                pk = frameMags[i];
                ix = i;
            end
        end
        expPeakQ.push_back(pk);
        expIdxQ.push_back(ix);
`ifdef PEAK_THRESHOLD_EN
        expDetQ.push_back(pk > thresholdVal);
`endif
        for (int i = 0; i < FL; i++) begin
            if (i == dropEnableAt) enable = 1'b0;
            applyStimulus(1'b1, frameMags[i], 0);
            if (toggle) applyStimulus(1'b0, 0, 0);
        end
        applyStimulus(1'b0, 0, 0);
    endtask

    task automatic waitReports(input int target, input string name);
        for (int c = 0; c < 60 && reportCount < target; c++) applyStimulus(1'b0, 0, 0);
        checkOutput(name, reportCount, target);
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        bus.dataInValid = 1'b0;
        bus.dataInRe = '0;
        bus.dataInIm = '0;
`ifdef PEAK_THRESHOLD_EN
        threshold = (DW+1)'(thresholdVal);
`endif
        expV1 = 1'b0; expV2 = 1'b0; expV3 = 1'b0;
        expM1 = 0; expM2 = 0; expM3 = 0; expMag = 0;

        repeat (3) tick();
        checkOutput("resetMagOut", int'(bus.magOut), 0);
        checkOutput("resetMagValid", int'(bus.magOutValid), 0);
        checkOutput("resetPeakValue", int'(bus.peakValue), 0);
        checkOutput("resetPeakIndex", int'(bus.peakIndex), 0);
        checkOutput("resetPeakFlag", int'(bus.peakValidFlag), 0);
        checkOutput("resetBusy", int'(busy), 0);
        reset = 1'b0;
        applyStimulus(1'b0, 0, 0);

        // Single sample: result must appear on the third rising edge after it is taken.
        applyStimulus(1'b1, 3000, -4000);
        applyStimulus(1'b0, 0, 0);
        checkOutput("latencyEarly", int'(bus.magOutValid), 0);
        applyStimulus(1'b0, 0, 0);
        checkOutput("latencyValid", int'(bus.magOutValid), 1);
        checkOutput("mag3000m4000", int'(bus.magOut), 5125);
        applyStimulus(1'b0, 0, 0);
        checkOutput("magHoldValid", int'(bus.magOutValid), 0);
        checkOutput("magHold", int'(bus.magOut), 5125);

        applyStimulus(1'b1, -32768, 0);
        applyStimulus(1'b1, -32768, -32768);
        applyStimulus(1'b0, 0, 0);
        checkOutput("magMinNegRe", int'(bus.magOut), 32768);
        applyStimulus(1'b0, 0, 0);
        checkOutput("magMinNegBoth", int'(bus.magOut), 45056);
        repeat (3) applyStimulus(1'b0, 0, 0);

        // Frame A then frame B back-to-back with enable held, enable dropped mid frame B.
        enable = 1'b1;
        repeat (2) applyStimulus(1'b0, 0, 0);
        checkOutput("busyRun", int'(busy), 1);
        frameMags = '{10, 50, 20, 50, 5, 5, 5, 5};
        sendFrame(1'b0, -1);
        waitReports(1, "frameAReport");
        checkOutput("frameAPeakLit", int'(bus.peakValue), 50);
        checkOutput("frameAIndexLit", int'(bus.peakIndex), 1);
        checkOutput("busyBetween", int'(busy), 1);
        frameMags = '{7, 3, 9, 9, 1, 2, 9, 4};
        sendFrame(1'b1, 4);
        waitReports(2, "frameBReport");
        checkOutput("frameBPeakLit", int'(bus.peakValue), 9);
        checkOutput("frameBIndexLit", int'(bus.peakIndex), 2);
        repeat (2) applyStimulus(1'b0, 0, 0);
        checkOutput("busyIdleAfterB", int'(busy), 0);

        // Reset halfway through a frame discards it entirely.
        enable = 1'b1;
        repeat (2) applyStimulus(1'b0, 0, 0);
        applyStimulus(1'b1, 200, 0);
        applyStimulus(1'b1, 300, 0);
        applyStimulus(1'b1, 400, 0);
        applyStimulus(1'b1, 500, 0);
        repeat (3) applyStimulus(1'b0, 0, 0);
        reset = 1'b1;
        enable = 1'b0;
        repeat (2) applyStimulus(1'b0, 0, 0);
        checkOutput("midResetPeakValue", int'(bus.peakValue), 0);
        checkOutput("midResetPeakIndex", int'(bus.peakIndex), 0);
        checkOutput("midResetBusy", int'(busy), 0);
        reset = 1'b0;
        repeat (4) applyStimulus(1'b0, 0, 0);
        checkOutput("noReportAfterReset", reportCount, 2);
        checkOutput("idleAfterReset", int'(busy), 0);

        enable = 1'b1;
        repeat (2) applyStimulus(1'b0, 0, 0);
        frameMags = '{0, 0, 0, 0, 0, 0, 0, 0};
        sendFrame(1'b0, -1);
        waitReports(3, "zeroFrameReport");
        checkOutput("zeroPeakLit", int'(bus.peakValue), 0);
        checkOutput("zeroIndexLit", int'(bus.peakIndex), 0);
        frameMags = '{1, 2, 3, 4, 5, 6, 7, 100};
        sendFrame(1'b0, -1);
        waitReports(4, "lastSampleReport");
        checkOutput("lastPeakLit", int'(bus.peakValue), 100);
        checkOutput("lastIndexLit", int'(bus.peakIndex), 7);

`ifdef PEAK_THRESHOLD_EN
        frameMags = '{20, 150, 30, 40, 50, 60, 70, 80};
        sendFrame(1'b0, -1);
        waitReports(5, "threshHighReport");
        checkOutput("detectHighLit", int'(detectFlag), 1);
        frameMags = '{20, 100, 30, 40, 50, 60, 70, 80};
        sendFrame(1'b0, -1);
        waitReports(6, "threshEqualReport");
        checkOutput("detectEqualLit", int'(detectFlag), 0);
`endif

        enable = 1'b0;
        repeat (4) applyStimulus(1'b0, 0, 0);
        checkOutput("scoreboardEmpty", expPeakQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
